// File: rtl/frame_pkg.sv
// Shared definitions for the channelised frame protocol: framing constants,
// the encoder state type and the word-parallel CRC-16/XMODEM step.
package frame_pkg;

  localparam logic [31:0] FRAME_HEADER  = 32'hE0E0_E0E0;
  localparam logic [31:0] FRAME_TRAILER = 32'h0E0E_0E0E;
  localparam logic [15:0] IDLE_WORD     = 16'h0000;
  localparam int          MAX_WORDS     = 8;
  localparam logic [15:0] CRC_POLY      = 16'h1021;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    CHAN,
    DATA,
    CRC,
    TRL0,
    TRL1
  } state_t;

  // Sixteen MSB-first shift/poly steps folded into one word update.
  function automatic logic [15:0] crc16_ccitt_w16(input logic [15:0] crc,
                                                  input logic [15:0] word);
    logic [15:0] c;
    c = crc ^ word;
    for (int i = 0; i < 16; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_par16.sv
// Registered CRC-16/XMODEM accumulator, one 16-bit word per enabled cycle.
// Clear has priority over enable so a new frame always starts from zero.
module crc16_par16
  import frame_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [15:0] i_word,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 16'h0000;
    end else if (i_clr) begin
      r_crc <= 16'h0000;
    end else if (i_en) begin
      r_crc <= crc16_ccitt_w16(r_crc, i_word);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/frame_encoder.sv
// Transmit framer: header, channel word, payload, CRC-16 and trailer, one
// registered 16-bit word per clock, with back-to-back acceptance in TRL1.
module frame_encoder
  import frame_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         req_vld,
  output logic         req_rdy,
  input  logic [7:0]   req_channel,
  input  logic [127:0] req_data,
  input  logic [3:0]   req_len,
  input  logic         req_crc_inj,
  output logic [15:0]  data_out,
  output logic         data_out_vld,
  output logic         tx_done
);

  localparam logic [3:0] MAX_LEN = 4'(MAX_WORDS);

  state_t         r_state;
  state_t         w_next;
  logic [127:0]   r_shift;
  logic [2:0]     r_cnt;
  logic [7:0]     r_chan;
  logic           r_inj;
  logic [15:0]    r_data_out;
  logic           r_vld;
  logic           r_done;
  logic           r_rdy;

  logic           w_accept;
  logic [3:0]     w_len;
  logic [7:0]     w_shamt;
  logic [15:0]    w_crc;
  logic [15:0]    w_data_nxt;
  logic           w_enter_data;

  assign w_accept     = req_vld && r_rdy;
  assign w_enter_data = (w_next == DATA);

  // NOTE: every always_comb output is given a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_len = req_len;
    if (req_len == 4'd0) begin
      w_len = 4'd1;
    end else if (req_len > MAX_LEN) begin
      w_len = MAX_LEN;
    end
  end

  // Left-align the N payload words so the first word sits in bits [127:112].
  assign w_shamt = {4'(MAX_LEN - w_len), 4'b0000};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = HDR0;
      HDR0:    w_next = HDR1;
      HDR1:    w_next = CHAN;
      CHAN:    w_next = DATA;
      DATA:    if (r_cnt == 3'd0) w_next = CRC;
      CRC:     w_next = TRL0;
      TRL0:    w_next = TRL1;
      TRL1:    w_next = w_accept ? HDR0 : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The output word is chosen from the state being entered, so it is on
  // data_out throughout the cycle the FSM spends in that state.
  always_comb begin
    w_data_nxt = IDLE_WORD;
    case (w_next)
      HDR0:    w_data_nxt = FRAME_HEADER[31:16];
      HDR1:    w_data_nxt = FRAME_HEADER[15:0];
      CHAN:    w_data_nxt = {8'h00, r_chan};
      DATA:    w_data_nxt = r_shift[127:112];
      CRC:     w_data_nxt = r_inj ? ~w_crc : w_crc;
      TRL0:    w_data_nxt = FRAME_TRAILER[31:16];
      TRL1:    w_data_nxt = FRAME_TRAILER[15:0];
      default: w_data_nxt = IDLE_WORD;
    endcase
  end

  crc16_par16 u_crc (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .i_clr  (w_accept),
    .i_en   (w_enter_data),
    .i_word (r_shift[127:112]),
    .o_crc  (w_crc)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= 3'd0;
      r_chan     <= 8'h00;
      r_inj      <= 1'b0;
      r_data_out <= IDLE_WORD;
      r_vld      <= 1'b0;
      r_done     <= 1'b0;
      r_rdy      <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_data_out <= w_data_nxt;
      r_vld      <= (w_next != IDLE);
      r_done     <= (w_next == TRL1);
      r_rdy      <= (w_next == IDLE) || (w_next == TRL1);

      if (w_accept) begin
        r_shift <= req_data << w_shamt;
        r_cnt   <= 3'(w_len - 4'd1);
        r_chan  <= req_channel;
        r_inj   <= req_crc_inj;
      end else begin
        if (w_enter_data) begin
          r_shift <= r_shift << 16;
        end
        if (r_state == DATA && r_cnt != 3'd0) begin
          r_cnt <= r_cnt - 3'd1;
        end
      end
    end
  end

  assign req_rdy      = r_rdy;
  assign data_out     = r_data_out;
  assign data_out_vld = r_vld;
  assign tx_done      = r_done;

endmodule

// File: tb/tb_frame_encoder.sv
// Self-checking bench for frame_encoder: directed spec cases plus random
// frames checked against a bit-serial, queue-based frame model.
module tb_frame_encoder;

  typedef struct packed {
    logic [15:0] w;
    logic        last;
  } exp_t;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic         req_vld;
  logic         req_rdy;
  logic [7:0]   req_channel;
  logic [127:0] req_data;
  logic [3:0]   req_len;
  logic         req_crc_inj;
  logic [15:0]  data_out;
  logic         data_out_vld;
  logic         tx_done;

  int n_cmp = 0;
  int n_err = 0;

  exp_t        exp_q[$];
  logic [15:0] cap [16];
  logic [15:0] last_frame [16];
  int          cap_idx  = 0;
  int          run      = 0;
  int          last_run = 0;

  logic [15:0] t1_words [7] = '{16'hE0E0, 16'hE0E0, 16'h0001, 16'hA55A,
                                16'h1934, 16'h0E0E, 16'h0E0E};
  logic [127:0] t3_data = 128'h0123456789ABCDEFFEDCBA9876543210;

  frame_encoder dut (
    .clk_in       (clk_in),
    .rst_n        (rst_n),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_channel  (req_channel),
    .req_data     (req_data),
    .req_len      (req_len),
    .req_crc_inj  (req_crc_inj),
    .data_out     (data_out),
    .data_out_vld (data_out_vld),
    .tx_done      (tx_done)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the frame is built from the protocol rules; the CRC is
  // computed bit-serially over the zero-padded 128-bit payload.
  function automatic void model_push(input logic [7:0] ch, input logic [127:0] d,
                                     input logic [3:0] len, input logic inj);
    int           n;
    logic [127:0] msg;
    logic [15:0]  crc;
    logic         fb;
    n   = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
    msg = d & ((128'd1 << (16 * n)) - 128'd1);
    crc = 16'h0000;
    for (int i = 127; i >= 0; i--) begin
      fb  = crc[15] ^ msg[i];
      crc = crc << 1;
      if (fb) crc = crc ^ 16'h1021;
    end
    exp_q.push_back('{w: 16'hE0E0, last: 1'b0});
    exp_q.push_back('{w: 16'hE0E0, last: 1'b0});
    exp_q.push_back('{w: {8'h00, ch}, last: 1'b0});
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{w: msg[16 * (n - 1 - k) +: 16], last: 1'b0});
    end
    exp_q.push_back('{w: inj ? ~crc : crc, last: 1'b0});
    exp_q.push_back('{w: 16'h0E0E, last: 1'b0});
    exp_q.push_back('{w: 16'h0E0E, last: 1'b1});
  endfunction

  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_n) begin
      cap_idx = 0;
      run     = 0;
    end else if (data_out_vld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {16'h0, data_out}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("word", {16'h0, data_out}, {16'h0, e.w});
        check("tx_done", {31'h0, tx_done}, {31'h0, e.last});
      end
      run++;
      if (cap_idx < 16) cap[cap_idx] = data_out;
      cap_idx++;
      if (tx_done) begin
        last_frame = cap;
        cap_idx    = 0;
      end
    end else begin
      check("idle_word", {16'h0, data_out}, 32'h0);
      check("idle_done", {31'h0, tx_done}, 32'h0);
      if (run != 0) begin
        last_run = run;
        run      = 0;
      end
    end
  end

  task automatic send(input logic [7:0] ch, input logic [127:0] d,
                      input logic [3:0] len, input logic inj);
    int waited = 0;
    @(negedge clk_in);
    req_channel = ch;
    req_data    = d;
    req_len     = len;
    req_crc_inj = inj;
    req_vld     = 1'b1;
    while (!req_rdy && waited < 100) begin
      @(negedge clk_in);
      waited++;
    end
    if (!req_rdy) begin
      check("accept_timeout", 32'h0, 32'h1);
      req_vld = 1'b0;
      return;
    end
    model_push(ch, d, len, inj);
    @(posedge clk_in);
    #1;
    req_vld     = 1'b0;
    req_data    = {$urandom, $urandom, $urandom, $urandom};
    req_channel = 8'($urandom);
    req_len     = 4'($urandom);
    req_crc_inj = 1'($urandom);
    @(negedge clk_in);
    check("latency_hdr0", {15'h0, data_out_vld, data_out}, {15'h0, 1'b1, 16'hE0E0});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((data_out_vld || exp_q.size() != 0) && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 300) check("idle_timeout", 32'h1, 32'h0);
    @(negedge clk_in);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_vld     = 1'b0;
    req_channel = 8'h00;
    req_data    = '0;
    req_len     = 4'd0;
    req_crc_inj = 1'b0;
    #12;
    check("rst_data", {16'h0, data_out}, 32'h0);
    check("rst_vld", {31'h0, data_out_vld}, 32'h0);
    check("rst_done", {31'h0, tx_done}, 32'h0);
    check("rst_rdy", {31'h0, req_rdy}, 32'h1);
    #10 rst_n = 1'b1;

    // Reference frame with known CRC.
    send(8'h01, 128'hA55A, 4'd1, 1'b0);
    wait_idle();
    check("t1_len", last_run, 7);
    for (int i = 0; i < 7; i++) check("t1_frame", {16'h0, last_frame[i]}, {16'h0, t1_words[i]});

    // Single-bit payload and CRC injection.
    send(8'h01, 128'h0001, 4'd1, 1'b0);
    wait_idle();
    check("t2_crc", {16'h0, last_frame[4]}, 32'h1021);
    send(8'h01, 128'h0001, 4'd1, 1'b1);
    wait_idle();
    check("t2_crc_inj", {16'h0, last_frame[4]}, 32'hEFDE);
    check("t2_data_inj", {16'h0, last_frame[3]}, 32'h0001);

    // Full-length payload ordering.
    send(8'h02, t3_data, 4'd8, 1'b0);
    wait_idle();
    check("t3_len", last_run, 14);
    check("t3_chan", {16'h0, last_frame[2]}, 32'h0002);
    for (int k = 0; k < 8; k++)
      check("t3_data", {16'h0, last_frame[3 + k]}, {16'h0, t3_data[127 - 16 * k -: 16]});

    // Back-to-back: two frames form one unbroken valid run.
    send(8'h04, 128'h1234_5678_9ABC, 4'd3, 1'b0);
    send(8'h08, 128'hDEAD_BEEF, 4'd2, 1'b0);
    wait_idle();
    check("b2b_run", last_run, 9 + 8);

    // Length clamping and verbatim channel.
    send(8'h10, {$urandom, $urandom, $urandom, $urandom}, 4'd0, 1'b0);
    wait_idle();
    check("len0_run", last_run, 7);
    send(8'h20, {$urandom, $urandom, $urandom, $urandom}, 4'd15, 1'b0);
    wait_idle();
    check("len15_run", last_run, 14);
    send(8'hE0, 128'h7, 4'd1, 1'b0);
    wait_idle();
    check("chan_e0", {16'h0, last_frame[2]}, 32'h00E0);

    // Reset in the middle of a 4-word payload.
    send(8'h40, 128'h1111_2222_3333_4444, 4'd4, 1'b0);
    repeat (3) @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_data", {16'h0, data_out}, 32'h0);
    check("midrst_vld", {31'h0, data_out_vld}, 32'h0);
    check("midrst_rdy", {31'h0, req_rdy}, 32'h1);
    exp_q.delete();
    @(negedge clk_in);
    #2 rst_n = 1'b1;
    send(8'h80, 128'h5555_6666_7777_8888, 4'd4, 1'b1);
    wait_idle();
    check("postrst_run", last_run, 10);

    // Random frames with random gaps, including back-to-back pairs.
    for (int t = 0; t < 30; t++) begin
      send(8'($urandom), {$urandom, $urandom, $urandom, $urandom},
           4'($urandom), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 12)) @(negedge clk_in);
    end
    wait_idle();
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
